adc_arbiter: RTL and testbench
==============================

# adc_arbiter

Shares one ADC handshake port (req pulse / rdy-low-while-busy / data valid on rdy rising) between N_CH independent acquisition requesters, e.g. several `data_acquire` instances. Each requester sees a private ADC-like interface (`ch_req_i` / `ch_rdy_o` / `ch_data_o`). The arbiter queues requests, grants the ADC round-robin, and runs exactly one conversion at a time. It returns each 12-bit result to the owning channel and recovers from a stuck ADC with a timeout.

## Interface
- `N_CH`, 4: number of requesters, 2..8.
- `DATA_W`, 12: ADC sample width.
- `TIMEOUT`, 64: max cycles spent in either wait state before abort, >= 4.

- `clk_i` in 1: single clock, all logic rising-edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `ch_req_i` in N_CH: per-channel conversion request; 1-cycle pulse, bit i = channel i.
- `ch_rdy_o` out N_CH: per-channel ready; low from request until result delivered.
- `ch_data_o` out N_CH*DATA_W: packed results, channel i at [i*DATA_W +: DATA_W], held until overwritten.
- `adc_data_req_o` out 1: 1-cycle conversion start pulse to ADC.
- `adc_data_rdy_i` in 1: ADC ready; low while converting, rising edge = data valid. Synchronous to `clk_i`.
- `adc_data_i` in DATA_W: ADC result, sampled on first cycle `adc_data_rdy_i` seen high in WAIT_DONE.
- `grant_o` out 3: index of channel owning the ADC (valid when `busy_o`).
- `busy_o` out 1: high in any state other than IDLE.
- `timeout_o` out 1: 1-cycle pulse when a conversion is aborted.

## Operation
- Reset values: `ch_rdy_o` all 1, `ch_data_o` 0, `adc_data_req_o` 0, `grant_o` 0, `busy_o` 0, `timeout_o` 0; pending bits 0; RR pointer = N_CH-1 (channel 0 wins first); FSM IDLE.
- Request capture: `ch_req_i[i]` high sets pending[i] and drives `ch_rdy_o[i]` low at that edge. A request on an already pending or active channel is merged (no second conversion).
- `ch_rdy_o[i]` = ~(pending[i] | (busy & grant==i)), registered.
- FSM:
  - IDLE: if any pending and `adc_data_rdy_i`=1, pick the first pending index after the RR pointer (mod N_CH), load `grant_o`, clear that pending bit, assert `adc_data_req_o`, go to REQ. If `adc_data_rdy_i`=0 (stale conversion), stay in IDLE.
  - REQ: `adc_data_req_o` deasserts, clear timer, go to WAIT_BUSY.
  - WAIT_BUSY: `adc_data_rdy_i`=0 -> clear timer, go to WAIT_DONE.
  - WAIT_DONE: `adc_data_rdy_i`=1 -> write `adc_data_i` to `ch_data_o[grant]`, RR pointer = grant, go to DONE.
  - DONE: `ch_rdy_o[grant]` goes high at this edge (if not re-pending), go to IDLE.
- Timeout: timer counts in WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT-1 -> `timeout_o` pulse, `ch_data_o` unchanged, RR pointer = grant, go to DONE (channel released with old data).
- Re-request by the granted channel during conversion sets pending. `ch_rdy_o` stays low through DONE, and the data still updates.

## Timing
- Idle arbiter, request sampled at edge E: `ch_rdy_o` low after E, `adc_data_req_o` high E+1..E+2, WAIT_BUSY from E+2.
- ADC rdy fall seen at edge F: WAIT_DONE from F. Rdy rise seen at edge R: data captured at R and visible after R. `ch_rdy_o` high after R+1.
- Back-to-back grants: next `adc_data_req_o` at R+2 at earliest (DONE, then IDLE arbitration).
- Simultaneous requests on all channels: served strictly in RR order, one per conversion, none lost.
- Reset mid-conversion: all state to reset values immediately. A later ADC rdy rise is ignored. New grants wait for `adc_data_rdy_i`=1.

## Configuration
- `ADC_ARB_TIMEOUT_EN` defined: timer, abort path and `timeout_o` pulse as above.
- Not defined: no timer, wait states block indefinitely, `timeout_o` tied 0, TIMEOUT unused.

## Test plan
- Reset then single request ch0, ADC busy 15 cycles, data 12'h014 -> one `adc_data_req_o` pulse, `ch_data_o[ch0]`=12'h014, `ch_rdy_o[0]` low then high, others stay 1.
- Requests ch0..ch3 same cycle, ADC returns 1,2,3,4 -> grants in order 0,1,2,3, and `ch_data_o` per channel = 1,2,3,4.
- After ch2 served, ch1 and ch3 pending -> ch3 granted before ch1 (RR pointer at 2).
- `ADC_ARB_TIMEOUT_EN`, ADC never drops rdy after request ch1 (TIMEOUT=64) -> `timeout_o` pulse 64 cycles into WAIT_BUSY, `ch_data_o[ch1]` unchanged, `ch_rdy_o[1]` high, next pending channel then served.
- Reset asserted during WAIT_DONE for ch2 with rdy still low -> outputs at reset values. New request ch0 not granted until rdy high, then converts normally with data 12'hFF1.
- Ch1 re-requests while its conversion active -> exactly two conversions for ch1, and `ch_rdy_o[1]` stays low until the second result.

Source files
------------

// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one ADC handshake port among N_CH requesters.
// Optional stuck-ADC abort timer is enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_arbiter #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [N_CH-1:0]          ch_req_i,
    output logic [N_CH-1:0]          ch_rdy_o,
    output logic [N_CH*DATA_W-1:0]   ch_data_o,
    output logic                     adc_data_req_o,
    input  logic                     adc_data_rdy_i,
    input  logic [DATA_W-1:0]        adc_data_i,
    output logic [2:0]               grant_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    // state       | meaning
    // S_IDLE      | wait for a pending channel and an idle ADC, then grant
    // S_REQ       | conversion start pulse on adc_data_req_o
    // S_WAIT_BUSY | wait for ADC to drop rdy (conversion started)
    // S_WAIT_DONE | wait for ADC rdy rise, capture result
    // S_DONE      | release the granted channel
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    // TIMEOUT only drives logic when the abort timer is built; this keeps it referenced otherwise.
    if (TIMEOUT < 4) begin : g_timeout_below_range
    end

    logic [2:0]      state, state_nxt;
    logic [N_CH-1:0] pending, pending_nxt, clr_mask;
    logic [2:0]      rr_ptr, rr_nxt;
    logic [2:0]      grant_nxt;
    logic            req_nxt;
    logic            data_we;
    logic [N_CH-1:0] rdy_nxt;
    logic [2:0]      pick_idx;
    logic            timer_tc;

    // First pending channel strictly after the round-robin pointer.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        logic [7:0] pend_ext;
        found    = 1'b0;
        pick_idx = 3'd0;
        idx      = 3'd0;
        pend_ext = 8'(pending);
        for (int k = 1; k <= N_CH; k++) begin
            idx = 3'((int'(rr_ptr) + k) % N_CH);
            if (!found && pend_ext[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clr_mask  = '0;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_o;
        req_nxt   = 1'b0;
        data_we   = 1'b0;
        case (state)
            S_IDLE: begin
                if ((|pending) && adc_data_rdy_i) begin
                    grant_nxt = pick_idx;
                    req_nxt   = 1'b1;
                    state_nxt = S_REQ;
                    for (int i = 0; i < N_CH; i++) begin
                        clr_mask[i] = (pick_idx == 3'(i));
                    end
                end
            end
            S_REQ: state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!adc_data_rdy_i) begin
                    state_nxt = S_WAIT_DONE;
                end else if (timer_tc) begin
                    rr_nxt    = grant_o;
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (adc_data_rdy_i) begin
                    data_we   = 1'b1;
                    rr_nxt    = grant_o;
                    state_nxt = S_DONE;
                end else if (timer_tc) begin
                    rr_nxt    = grant_o;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A request on the channel being granted this cycle merges into that grant.
        pending_nxt = (pending | ch_req_i) & ~clr_mask;
    end

    always_comb begin
        rdy_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            rdy_nxt[i] = ~(pending_nxt[i] | ((state_nxt != S_IDLE) && (grant_nxt == 3'(i))));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= S_IDLE;
            pending        <= '0;
            rr_ptr         <= 3'(N_CH - 1);
            grant_o        <= 3'd0;
            adc_data_req_o <= 1'b0;
            ch_rdy_o       <= '1;
            ch_data_o      <= '0;
        end else begin
            state          <= state_nxt;
            pending        <= pending_nxt;
            rr_ptr         <= rr_nxt;
            grant_o        <= grant_nxt;
            adc_data_req_o <= req_nxt;
            ch_rdy_o       <= rdy_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (data_we && (grant_o == 3'(i))) begin
                    ch_data_o[i*DATA_W +: DATA_W] <= adc_data_i;
                end
            end
        end
    end

    assign busy_o = (state != S_IDLE);

`ifdef ADC_ARB_TIMEOUT_EN
    localparam int                 TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] timer;

    assign timer_tc = (timer == '0);

    // Down-counter reloaded on entry to each wait state; terminal count aborts the conversion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer     <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timer_tc &&
                         (((state == S_WAIT_BUSY) &&  adc_data_rdy_i) ||
                          ((state == S_WAIT_DONE) && !adc_data_rdy_i));
            if ((state == S_REQ) || ((state == S_WAIT_BUSY) && !adc_data_rdy_i)) begin
                timer <= TIMER_LOAD;
            end else if (((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && !timer_tc) begin
                timer <= timer - TIMER_W'(1);
            end
        end
    end
`else
    assign timer_tc  = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_adc_arbiter.sv
// Scoreboard bench for adc_arbiter: behavioural ADC, grant and result queues checked by a monitor.
module tb_adc_arbiter;

    localparam int N_CH   = 4;
    localparam int DATA_W = 12;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_CH-1:0]        ch_req = '0;
    logic [N_CH-1:0]        ch_rdy_o;
    logic [N_CH*DATA_W-1:0] ch_data_o;
    logic                   adc_data_req_o;
    logic                   adc_rdy;
    logic [DATA_W-1:0]      adc_data;
    logic [2:0]             grant_o;
    logic                   busy_o;
    logic                   timeout_o;

    int tests = 0;
    int fails = 0;

    int                adc_busy  = 10;
    bit                adc_stuck = 1'b0;
    logic [DATA_W-1:0] adc_vals[$];
    int                exp_grant[$];
    logic [15:0]       exp_res[$];

    adc_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .TIMEOUT(64)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .ch_req_i       (ch_req),
        .ch_rdy_o       (ch_rdy_o),
        .ch_data_o      (ch_data_o),
        .adc_data_req_o (adc_data_req_o),
        .adc_data_rdy_i (adc_rdy),
        .adc_data_i     (adc_data),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ch_data(input int ch);
        return ch_data_o[ch*DATA_W +: DATA_W];
    endfunction

    // Behavioural ADC: drops rdy after a start pulse, raises it with the next queued sample.
    initial begin
        adc_rdy  = 1'b1;
        adc_data = '0;
        forever begin
            @(posedge clk); #1;
            if (adc_data_req_o && !adc_stuck) begin
                @(negedge clk);
                adc_rdy = 1'b0;
                repeat (adc_busy) @(negedge clk);
                adc_data = (adc_vals.size() > 0) ? adc_vals.pop_front() : '0;
                adc_rdy  = 1'b1;
            end
        end
    end

    // Monitor: start pulses are checked against expected grants, rdy rises against expected results.
    initial begin
        logic [N_CH-1:0] prev;
        logic [15:0]     e;
        prev = '1;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                prev = ch_rdy_o;
                continue;
            end
            if (adc_data_req_o) begin
                if (exp_grant.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_grant: grant_o=%0d with no grant expected", grant_o);
                end else begin
                    check("grant_order", 32'(grant_o), 32'(exp_grant.pop_front()));
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (ch_rdy_o[i] && !prev[i]) begin
                    if (exp_res.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_release: ch_rdy_o[%0d] rose, no result expected", i);
                    end else begin
                        e = exp_res.pop_front();
                        check("release_channel", 32'(i), 32'(e[15:12]));
                        check("release_data", 32'(ch_data(i)), 32'(e[11:0]));
                    end
                end
            end
            prev = ch_rdy_o;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_ch_rdy"},  32'(ch_rdy_o), 32'hF);
        check({tag, "_ch_data"}, 32'(ch_data_o[31:0] | ch_data_o[47:32]), 32'h0);
        check({tag, "_adc_req"}, 32'(adc_data_req_o), 32'h0);
        check({tag, "_grant"},   32'(grant_o), 32'h0);
        check({tag, "_busy"},    32'(busy_o), 32'h0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_req(input logic [N_CH-1:0] m);
        @(negedge clk);
        ch_req = m;
        @(posedge clk); #1;
        ch_req = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_grant.size() != 0 || exp_res.size() != 0 || busy_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_idle: not idle after %0d cycles, grants left %0d, results left %0d, expected all 0",
                     name, n, exp_grant.size(), exp_res.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_adc_low(input int budget);
        int n;
        n = 0;
        while (adc_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("adc_started", 32'(adc_rdy), 32'h0);
    endtask

    initial begin
        do_reset();
        #1;
        reset_checks("reset");

        // Single request on ch0 with timing checks around the start pulse.
        adc_busy = 15;
        adc_vals.push_back(12'h014);
        exp_grant.push_back(0);
        exp_res.push_back({4'd0, 12'h014});
        pulse_req(4'b0001);
        check("t1_rdy_low", 32'(ch_rdy_o), 32'hE);
        check("t1_req_not_yet", 32'(adc_data_req_o), 32'h0);
        @(posedge clk); #1;
        check("t1_req_high", 32'(adc_data_req_o), 32'h1);
        check("t1_busy", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        check("t1_req_single", 32'(adc_data_req_o), 32'h0);
        wait_idle("t1", 200);
        check("t1_data_ch0", 32'(ch_data(0)), 32'h014);
        check("t1_rdy_all", 32'(ch_rdy_o), 32'hF);

        // All channels at once from reset: order 0,1,2,3.
        do_reset();
        adc_busy = 6;
        for (int i = 0; i < N_CH; i++) begin
            adc_vals.push_back(12'(i + 1));
            exp_grant.push_back(i);
            exp_res.push_back({4'(i), 12'(i + 1)});
        end
        pulse_req(4'b1111);
        check("t2_rdy_all_low", 32'(ch_rdy_o), 32'h0);
        wait_idle("t2", 400);
        for (int i = 0; i < N_CH; i++) begin
            check("t2_data", 32'(ch_data(i)), 32'(i + 1));
        end

        // ch2 served first, then ch1 and ch3 pending: ch3 wins next.
        do_reset();
        adc_busy = 8;
        adc_vals.push_back(12'hA02);
        adc_vals.push_back(12'hA03);
        adc_vals.push_back(12'hA01);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        exp_res.push_back({4'd2, 12'hA02});
        exp_res.push_back({4'd3, 12'hA03});
        exp_res.push_back({4'd1, 12'hA01});
        pulse_req(4'b0100);
        wait_adc_low(20);
        pulse_req(4'b1010);
        wait_idle("t3", 300);
        check("t3_data_ch1", 32'(ch_data(1)), 32'hA01);
        check("t3_data_ch3", 32'(ch_data(3)), 32'hA03);

`ifdef ADC_ARB_TIMEOUT_EN
        // ADC ignores the start pulse for ch1; abort after 64 cycles in WAIT_BUSY, then ch3 served.
        begin
            int n;
            do_reset();
            adc_stuck = 1'b1;
            adc_busy  = 5;
            adc_vals.push_back(12'h333);
            exp_grant.push_back(1);
            exp_grant.push_back(3);
            exp_res.push_back({4'd1, 12'h000});
            exp_res.push_back({4'd3, 12'h333});
            pulse_req(4'b1010);
            n = 0;
            while (!adc_data_req_o && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            n = 0;
            while (!timeout_o && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("t4_timeout_latency", 32'(n), 32'd65);
            check("t4_data_ch1_kept", 32'(ch_data(1)), 32'h000);
            @(negedge clk);
            adc_stuck = 1'b0;
            @(posedge clk); #1;
            check("t4_timeout_pulse", 32'(timeout_o), 32'h0);
            check("t4_rdy_ch1", 32'(ch_rdy_o[1]), 32'h1);
            wait_idle("t4", 300);
            check("t4_data_ch3", 32'(ch_data(3)), 32'h333);
        end
`endif

        // Reset while ch2 is in WAIT_DONE; later rdy rise is ignored, ch0 waits for rdy.
        do_reset();
        adc_busy = 40;
        adc_vals.push_back(12'h777);
        adc_vals.push_back(12'hFF1);
        exp_grant.push_back(2);
        pulse_req(4'b0100);
        wait_adc_low(20);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_checks("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        adc_busy = 6;
        exp_grant.push_back(0);
        exp_res.push_back({4'd0, 12'hFF1});
        pulse_req(4'b0001);
        repeat (5) @(negedge clk);
        check("t5_no_grant_busy", 32'(busy_o), 32'h0);
        check("t5_ch0_pending", 32'(ch_rdy_o), 32'hE);
        wait_idle("t5", 300);
        check("t5_data_ch0", 32'(ch_data(0)), 32'hFF1);
        check("t5_data_ch2", 32'(ch_data(2)), 32'h000);

        // ch1 re-requests during its own conversion: two conversions, one release.
        do_reset();
        adc_busy = 8;
        adc_vals.push_back(12'h111);
        adc_vals.push_back(12'h122);
        exp_grant.push_back(1);
        exp_grant.push_back(1);
        exp_res.push_back({4'd1, 12'h122});
        pulse_req(4'b0010);
        wait_adc_low(20);
        repeat (2) @(negedge clk);
        pulse_req(4'b0010);
        wait_idle("t6", 300);
        check("t6_data_ch1", 32'(ch_data(1)), 32'h122);
        check("t6_rdy_all", 32'(ch_rdy_o), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
